// File: rtl/nf_uart_tx_arbiter.sv
// nf_uart_tx_arbiter: round-robin arbiter sharing one UART transmitter between
// N_SRC byte-stream requesters. A granted requester keeps the transmitter until
// its last byte is acknowledged, or until it stays silent for TIMEOUT cycles.
module nf_uart_tx_arbiter #(
    parameter int unsigned N_SRC   = 4,
    parameter int unsigned TIMEOUT = 1024,
    localparam int unsigned IdW    = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 en,
    input  logic [N_SRC-1:0]     src_valid,
    input  logic [8*N_SRC-1:0]   src_data,
    input  logic [N_SRC-1:0]     src_last,
    output logic [N_SRC-1:0]     src_ready,
    output logic [7:0]           tx_data,
    output logic                 req,
    input  logic                 req_ack,
    output logic                 tr_en,
    output logic [IdW-1:0]       grant_id,
    output logic                 busy,
    output logic                 timeout
);

    localparam int unsigned CntW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {StIdle, StReq, StWait, StHold} state_e;

    state_e          state_q, state_d;
    logic [IdW-1:0]  rr_ptr_q, rr_ptr_d;
    logic [IdW-1:0]  grant_id_q, grant_id_d;
    logic [7:0]      tx_data_q, tx_data_d;
    logic            req_q, req_d;
    logic            timeout_q, timeout_d;
    logic            last_r_q, last_r_d;
    logic [CntW-1:0] tmo_cnt_q, tmo_cnt_d;

    logic [IdW-1:0]  winner;
    logic [IdW-1:0]  cand;
    logic            win_found;
    logic [IdW-1:0]  next_ptr;
    logic [N_SRC-1:0] ready_vec;

    // Round-robin search: first valid requester starting at rr_ptr.
    always_comb begin
        winner    = '0;
        cand      = '0;
        win_found = 1'b0;
        for (int unsigned k = 0; k < N_SRC; k++) begin
            cand = IdW'((32'(rr_ptr_q) + k) % N_SRC);
            if (!win_found && src_valid[cand]) begin
                win_found = 1'b1;
                winner    = cand;
            end
        end
    end

    // The owner just served becomes lowest priority next time round.
    assign next_ptr = IdW'((32'(grant_id_q) + 1) % N_SRC);

    // Next-state and per-requester ready decode.
    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        grant_id_d = grant_id_q;
        tx_data_d  = tx_data_q;
        req_d      = 1'b0;
        timeout_d  = 1'b0;
        last_r_d   = last_r_q;
        tmo_cnt_d  = tmo_cnt_q;
        ready_vec  = '0;
        unique case (state_q)
            StIdle: begin
                if (en && win_found) begin
                    ready_vec[winner] = 1'b1;
                    grant_id_d        = winner;
                    tx_data_d         = src_data[{winner, 3'b000} +: 8];
                    last_r_d          = src_last[winner];
                    req_d             = 1'b1;
                    state_d           = StReq;
                end
            end
            StReq: begin
                // req_ack seen here belongs to no byte of ours yet.
                state_d = StWait;
            end
            StWait: begin
                if (req_ack) begin
                    if (last_r_q) begin
                        rr_ptr_d = next_ptr;
                        state_d  = StIdle;
                    end else begin
                        tmo_cnt_d = '0;
                        state_d   = StHold;
                    end
                end
            end
            StHold: begin
                ready_vec[grant_id_q] = 1'b1;
                if (src_valid[grant_id_q]) begin
                    tx_data_d = src_data[{grant_id_q, 3'b000} +: 8];
                    last_r_d  = src_last[grant_id_q];
                    req_d     = 1'b1;
                    state_d   = StReq;
                end else if (tmo_cnt_q == CntW'(TIMEOUT - 1)) begin
                    timeout_d = 1'b1;
                    rr_ptr_d  = next_ptr;
                    state_d   = StIdle;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State registers with asynchronous active-high reset.
    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            state_q    <= StIdle;
            rr_ptr_q   <= '0;
            grant_id_q <= '0;
            tx_data_q  <= '0;
            req_q      <= 1'b0;
            timeout_q  <= 1'b0;
            last_r_q   <= 1'b0;
            tmo_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            grant_id_q <= grant_id_d;
            tx_data_q  <= tx_data_d;
            req_q      <= req_d;
            timeout_q  <= timeout_d;
            last_r_q   <= last_r_d;
            tmo_cnt_q  <= tmo_cnt_d;
        end
    end

    // Ready is forced low while reset is held, even if IDLE sees valid requests.
    assign src_ready = resetn ? '0 : ready_vec;
    assign busy      = (state_q != StIdle);
    assign tr_en     = en | busy;
    assign tx_data   = tx_data_q;
    assign req       = req_q;
    assign grant_id  = grant_id_q;
    assign timeout   = timeout_q;

endmodule

// File: tb/tb_nf_uart_tx_arbiter.sv
// Self-checking bench for nf_uart_tx_arbiter: directed scenarios followed by a
// randomized multi-source run checked against a message-level reference model.
module tb_nf_uart_tx_arbiter;

    localparam int N   = 4;
    localparam int TMO = 16;

    logic         clk;
    logic         resetn;
    logic         en;
    logic [N-1:0] src_valid;
    logic [8*N-1:0] src_data;
    logic [N-1:0] src_last;
    logic [N-1:0] src_ready;
    logic [7:0]   tx_data;
    logic         req;
    logic         req_ack;
    logic         tr_en;
    logic [1:0]   grant_id;
    logic         busy;
    logic         timeout;

    int vectors    = 0;
    int miscompares = 0;

    nf_uart_tx_arbiter #(.N_SRC(N), .TIMEOUT(TMO)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .en        (en),
        .src_valid (src_valid),
        .src_data  (src_data),
        .src_last  (src_last),
        .src_ready (src_ready),
        .tx_data   (tx_data),
        .req       (req),
        .req_ack   (req_ack),
        .tr_en     (tr_en),
        .grant_id  (grant_id),
        .busy      (busy),
        .timeout   (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_reset();
        resetn    = 1'b1;
        en        = 1'b0;
        src_valid = '0;
        src_last  = '0;
        src_data  = '0;
        req_ack   = 1'b0;
        repeat (2) @(posedge clk);
        #1 resetn = 1'b0;
    endtask

    // Accept edge, then REQ->WAIT edge, then one-cycle ack sampled in WAIT.
    task automatic serve_byte(input int idx, input logic [7:0] nb, input logic nl,
                              input logic nv);
        @(posedge clk); #1;
        src_data[8*idx +: 8] = nb;
        src_last[idx]        = nl;
        src_valid[idx]       = nv;
        @(posedge clk); #1;
        req_ack = 1'b1;
        @(posedge clk); #1;
        req_ack = 1'b0;
    endtask

    task automatic test_reset();
        resetn    = 1'b1;
        en        = 1'b1;
        src_valid = 4'hF;
        src_last  = 4'hF;
        src_data  = 32'hA5A5_A5A5;
        req_ack   = 1'b0;
        @(negedge clk);
        vectors++;
        if (src_ready !== 4'b0000 || req !== 1'b0 || busy !== 1'b0 || timeout !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_ctrl: ready=%b req=%b busy=%b tmo=%b, required 0000/0/0/0",
                     src_ready, req, busy, timeout);
        end
        vectors++;
        if (grant_id !== 2'd0 || tx_data !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_regs: grant_id=%0d tx_data=%h, required 0/00", grant_id, tx_data);
        end
        vectors++;
        if (tr_en !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_tr_en_hi: tr_en=%b, required 1", tr_en);
        end
        en = 1'b0;
        #1;
        vectors++;
        if (tr_en !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_tr_en_lo: tr_en=%b, required 0", tr_en);
        end
    endtask

    task automatic test_single();
        do_reset();
        en            = 1'b1;
        src_data[7:0] = 8'h48;
        src_last[0]   = 1'b0;
        src_valid[0]  = 1'b1;
        @(negedge clk);
        vectors++;
        if (src_ready !== 4'b0001 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL single_accept0: ready=%b busy=%b, required 0001/0", src_ready, busy);
        end
        @(posedge clk); #1;
        src_valid[0] = 1'b0;
        req_ack      = 1'b1;   // ack during REQ must be ignored
        @(negedge clk);
        vectors++;
        if (req !== 1'b1 || tx_data !== 8'h48 || grant_id !== 2'd0) begin
            miscompares++;
            $display("FAIL single_req0: req=%b tx=%h gid=%0d, required 1/48/0", req, tx_data,
                     grant_id);
        end
        @(posedge clk); #1;
        req_ack = 1'b0;
        @(negedge clk);
        vectors++;
        if (req !== 1'b0 || busy !== 1'b1 || src_ready !== 4'b0000) begin
            miscompares++;
            $display("FAIL single_wait: req=%b busy=%b ready=%b, required 0/1/0000", req, busy,
                     src_ready);
        end
        @(posedge clk); #1;
        req_ack = 1'b1;
        @(posedge clk); #1;
        req_ack       = 1'b0;
        src_data[7:0] = 8'h69;
        src_last[0]   = 1'b1;
        src_valid[0]  = 1'b1;
        @(negedge clk);
        vectors++;
        if (src_ready !== 4'b0001 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL single_hold: ready=%b busy=%b, required 0001/1", src_ready, busy);
        end
        @(posedge clk); #1;
        src_valid[0] = 1'b0;
        @(negedge clk);
        vectors++;
        if (req !== 1'b1 || tx_data !== 8'h69) begin
            miscompares++;
            $display("FAIL single_req1: req=%b tx=%h, required 1/69", req, tx_data);
        end
        @(posedge clk); #1;
        req_ack = 1'b1;
        @(posedge clk); #1;
        req_ack = 1'b0;
        @(negedge clk);
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL single_done: busy=%b, required 0", busy);
        end
        src_valid = 4'b0011;
        src_last  = 4'b0011;
        #1;
        vectors++;
        if (src_ready !== 4'b0010) begin
            miscompares++;
            $display("FAIL single_rr_ptr: ready=%b, required 0010", src_ready);
        end
    endtask

    task automatic test_contention();
        do_reset();
        en             = 1'b1;
        src_data[15:8] = 8'h11;
        src_data[31:24] = 8'h33;
        src_last       = 4'b1010;
        src_valid      = 4'b1010;
        @(negedge clk);
        vectors++;
        if (src_ready !== 4'b0010) begin
            miscompares++;
            $display("FAIL cont_first: ready=%b, required 0010", src_ready);
        end
        serve_byte(1, 8'h12, 1'b1, 1'b1);
        @(negedge clk);
        vectors++;
        if (src_ready !== 4'b1000 || grant_id !== 2'd1) begin
            miscompares++;
            $display("FAIL cont_second: ready=%b gid=%0d, required 1000/1", src_ready, grant_id);
        end
        serve_byte(3, 8'h34, 1'b1, 1'b1);
        @(negedge clk);
        vectors++;
        if (src_ready !== 4'b0010 || grant_id !== 2'd3) begin
            miscompares++;
            $display("FAIL cont_third: ready=%b gid=%0d, required 0010/3", src_ready, grant_id);
        end
        serve_byte(1, 8'h00, 1'b1, 1'b0);
        @(negedge clk);
        vectors++;
        if (src_ready !== 4'b1000) begin
            miscompares++;
            $display("FAIL cont_fourth: ready=%b, required 1000", src_ready);
        end
    endtask

    task automatic test_lock();
        do_reset();
        en              = 1'b1;
        src_data[7:0]   = 8'h41;
        src_data[23:16] = 8'h77;
        src_last        = 4'b0100;
        src_valid       = 4'b0101;
        @(negedge clk);
        vectors++;
        if (src_ready !== 4'b0001) begin
            miscompares++;
            $display("FAIL lock_first: ready=%b, required 0001", src_ready);
        end
        serve_byte(0, 8'h42, 1'b0, 1'b1);
        @(negedge clk);
        vectors++;
        if (src_ready !== 4'b0001 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL lock_hold_b: ready=%b busy=%b, required 0001/1", src_ready, busy);
        end
        serve_byte(0, 8'h43, 1'b1, 1'b1);
        @(negedge clk);
        vectors++;
        if (src_ready !== 4'b0001) begin
            miscompares++;
            $display("FAIL lock_hold_c: ready=%b, required 0001", src_ready);
        end
        serve_byte(0, 8'h44, 1'b1, 1'b1);
        @(negedge clk);
        vectors++;
        if (src_ready !== 4'b0100) begin
            miscompares++;
            $display("FAIL lock_release: ready=%b, required 0100", src_ready);
        end
        @(posedge clk); #1;
        src_valid[2] = 1'b0;
        @(negedge clk);
        vectors++;
        if (grant_id !== 2'd2 || tx_data !== 8'h77 || req !== 1'b1) begin
            miscompares++;
            $display("FAIL lock_grant2: gid=%0d tx=%h req=%b, required 2/77/1", grant_id,
                     tx_data, req);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        en             = 1'b1;
        src_data[15:8] = 8'h5A;
        src_last[1]    = 1'b0;
        src_valid[1]   = 1'b1;
        @(negedge clk);
        vectors++;
        if (src_ready !== 4'b0010) begin
            miscompares++;
            $display("FAIL tmo_accept: ready=%b, required 0010", src_ready);
        end
        serve_byte(1, 8'h00, 1'b0, 1'b0);
        for (int k = 1; k < TMO; k++) begin
            @(posedge clk); #1;
            vectors++;
            if (timeout !== 1'b0 || busy !== 1'b1) begin
                miscompares++;
                $display("FAIL tmo_early: cycle %0d tmo=%b busy=%b, required 0/1", k, timeout,
                         busy);
            end
        end
        @(posedge clk); #1;
        vectors++;
        if (timeout !== 1'b1 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL tmo_pulse: tmo=%b busy=%b, required 1/0", timeout, busy);
        end
        src_last  = 4'b0111;
        src_valid = 4'b0111;
        @(negedge clk);
        vectors++;
        if (src_ready !== 4'b0100) begin
            miscompares++;
            $display("FAIL tmo_next_grant: ready=%b, required 0100", src_ready);
        end
        @(posedge clk); #1;
        vectors++;
        if (timeout !== 1'b0) begin
            miscompares++;
            $display("FAIL tmo_one_cycle: tmo=%b, required 0", timeout);
        end
    endtask

    task automatic test_enable();
        do_reset();
        en            = 1'b1;
        src_data[7:0] = 8'hE1;
        src_last[0]   = 1'b0;
        src_valid[0]  = 1'b1;
        @(negedge clk);
        vectors++;
        if (src_ready !== 4'b0001) begin
            miscompares++;
            $display("FAIL en_accept: ready=%b, required 0001", src_ready);
        end
        @(posedge clk); #1;
        src_data[7:0] = 8'hE2;
        src_last[0]   = 1'b1;
        @(posedge clk); #1;
        en = 1'b0;
        @(negedge clk);
        vectors++;
        if (tr_en !== 1'b1 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL en_wait_tr_en: tr_en=%b busy=%b, required 1/1", tr_en, busy);
        end
        @(posedge clk); #1;
        req_ack = 1'b1;
        @(posedge clk); #1;
        req_ack = 1'b0;
        @(negedge clk);
        vectors++;
        if (src_ready !== 4'b0001 || tr_en !== 1'b1) begin
            miscompares++;
            $display("FAIL en_hold: ready=%b tr_en=%b, required 0001/1", src_ready, tr_en);
        end
        serve_byte(0, 8'h00, 1'b1, 1'b0);
        src_valid = 4'b0011;
        src_last  = 4'b0011;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            vectors++;
            if (tr_en !== 1'b0 || busy !== 1'b0 || src_ready !== 4'b0000 || req !== 1'b0) begin
                miscompares++;
                $display("FAIL en_blocked: tr_en=%b busy=%b ready=%b req=%b, required 0/0/0000/0",
                         tr_en, busy, src_ready, req);
            end
        end
        @(posedge clk); #1;
        en = 1'b1;
        @(negedge clk);
        vectors++;
        if (src_ready !== 4'b0010) begin
            miscompares++;
            $display("FAIL en_regrant: ready=%b, required 0010", src_ready);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        en              = 1'b1;
        src_data[23:16] = 8'hC3;
        src_last[2]     = 1'b0;
        src_valid[2]    = 1'b1;
        @(negedge clk);
        vectors++;
        if (src_ready !== 4'b0100) begin
            miscompares++;
            $display("FAIL arst_accept: ready=%b, required 0100", src_ready);
        end
        @(posedge clk); #1;
        @(posedge clk); #2;
        resetn = 1'b1;
        #1;
        vectors++;
        if (req !== 1'b0 || busy !== 1'b0 || src_ready !== 4'b0000 || grant_id !== 2'd0 ||
            tx_data !== 8'h00) begin
            miscompares++;
            $display("FAIL arst_wait: req=%b busy=%b ready=%b gid=%0d tx=%h, required 0/0/0000/0/00",
                     req, busy, src_ready, grant_id, tx_data);
        end
        src_valid = '0;
        @(posedge clk); #1;
        resetn = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            vectors++;
            if (req !== 1'b0 || busy !== 1'b0) begin
                miscompares++;
                $display("FAIL arst_quiet: req=%b busy=%b, required 0/0", req, busy);
            end
        end
        src_data[31:24] = 8'h3C;
        src_last[3]     = 1'b1;
        src_valid[3]    = 1'b1;
        #1;
        vectors++;
        if (src_ready !== 4'b1000) begin
            miscompares++;
            $display("FAIL arst_new_accept: ready=%b, required 1000", src_ready);
        end
        @(posedge clk); #1;
        src_valid[3] = 1'b0;
        @(negedge clk);
        vectors++;
        if (req !== 1'b1 || tx_data !== 8'h3C) begin
            miscompares++;
            $display("FAIL arst_new_req: req=%b tx=%h, required 1/3C", req, tx_data);
        end
        resetn = 1'b1;
        #1;
        vectors++;
        if (req !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL arst_req: req=%b busy=%b, required 0/0", req, busy);
        end
        @(posedge clk); #1;
        resetn = 1'b0;
    endtask

    // Random traffic: each source emits random messages with random gaps; the
    // model tracks the lock owner and the round-robin pointer at message level.
    task automatic test_random();
        int unsigned msgs_left[N];
        int unsigned len_left[N];
        int unsigned gap[N];
        logic [N-1:0] fire;
        logic [N-1:0] exp_fire;
        logic [7:0]   exp_byte;
        int  owner, ptr, exp_win, ack_wait, idx;
        bit  locked, in_hold, pend_req, inflight_last, acking, done;
        do_reset();
        en = 1'b1;
        ptr = 0; owner = 0; ack_wait = 0; exp_byte = '0;
        locked = 0; in_hold = 0; pend_req = 0; inflight_last = 0; acking = 0; done = 0;
        for (int i = 0; i < N; i++) begin
            msgs_left[i] = $urandom_range(2, 5);
            len_left[i]  = $urandom_range(1, 3);
            gap[i]       = $urandom_range(0, 3);
        end
        for (int cyc = 0; cyc < 4000 && !done; cyc++) begin
            for (int i = 0; i < N; i++) begin
                if (!src_valid[i] && msgs_left[i] != 0) begin
                    if (gap[i] != 0) begin
                        gap[i]--;
                    end else begin
                        src_valid[i]         = 1'b1;
                        src_data[8*i +: 8]   = 8'($urandom);
                        src_last[i]          = (len_left[i] == 1);
                    end
                end
            end
            @(negedge clk);
            fire = src_valid & src_ready;
            vectors++;
            if ($countones(src_ready) > 1 || timeout !== 1'b0) begin
                miscompares++;
                $display("FAIL rnd_onehot: ready=%b tmo=%b, required at most one ready, tmo 0",
                         src_ready, timeout);
            end
            vectors++;
            if (pend_req) begin
                if (req !== 1'b1 || tx_data !== exp_byte) begin
                    miscompares++;
                    $display("FAIL rnd_req: req=%b tx=%h, required 1/%h", req, tx_data, exp_byte);
                end
                pend_req = 0;
                ack_wait = $urandom_range(1, 4);
            end else if (req !== 1'b0) begin
                miscompares++;
                $display("FAIL rnd_spurious_req: req=%b, required 0", req);
            end
            exp_fire = '0;
            exp_win  = -1;
            if (!locked) begin
                for (int k = 0; k < N; k++) begin
                    if (exp_win < 0 && src_valid[(ptr + k) % N]) exp_win = (ptr + k) % N;
                end
                if (exp_win >= 0) exp_fire[exp_win] = 1'b1;
            end else if (in_hold && src_valid[owner]) begin
                exp_fire[owner] = 1'b1;
            end
            vectors++;
            if (fire !== exp_fire) begin
                miscompares++;
                $display("FAIL rnd_grant: fire=%b, required %b (ptr=%0d owner=%0d)", fire,
                         exp_fire, ptr, owner);
            end
            idx = -1;
            if (exp_fire != '0) begin
                if (!locked) owner = exp_win;
                idx           = owner;
                locked        = 1;
                in_hold       = 0;
                exp_byte      = src_data[8*owner +: 8];
                inflight_last = src_last[owner];
                pend_req      = 1;
            end
            @(posedge clk); #1;
            if (acking) begin
                req_ack = 1'b0;
                acking  = 0;
                if (inflight_last) begin
                    locked = 0;
                    ptr    = (owner + 1) % N;
                end else begin
                    in_hold = 1;
                end
            end else if (ack_wait != 0) begin
                ack_wait--;
                if (ack_wait == 0) begin
                    req_ack = 1'b1;
                    acking  = 1;
                end
            end
            if (idx >= 0) begin
                src_valid[idx] = 1'b0;
                gap[idx]       = $urandom_range(0, 3);
                if (src_last[idx]) begin
                    msgs_left[idx]--;
                    len_left[idx] = $urandom_range(1, 3);
                end else begin
                    len_left[idx]--;
                end
            end
            done = !locked && !pend_req && !acking;
            for (int i = 0; i < N; i++) if (msgs_left[i] != 0) done = 0;
        end
        vectors++;
        if (!done) begin
            miscompares++;
            $display("FAIL rnd_budget: traffic incomplete after cycle budget, required completion");
        end
    endtask

    initial begin
        resetn    = 1'b1;
        en        = 1'b0;
        src_valid = '0;
        src_last  = '0;
        src_data  = '0;
        req_ack   = 1'b0;
        test_reset();
        test_single();
        test_contention();
        test_lock();
        test_timeout();
        test_enable();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
